// File: rtl/packet_sorter.sv
// rtl/packet_sorter.sv - buffers one packet, sorts it by odd-even transposition, streams it back out
//
// Parameters: DWIDTH (word width), MAX_PKT_LEN (stored words per packet),
//             SIGNED_DATA (0 unsigned compare, 1 two's-complement compare)
// Ports:
//   clk_i, arst_ni                   clock, asynchronous active-low reset
//   snk_data_i/startofpacket_i/
//   endofpacket_i/valid_i            sink word, framing and valid
//   snk_ready_o                      sink accepts a word (IDLE/RECEIVING only)
//   src_data_o/startofpacket_o/
//   endofpacket_o/valid_o            sorted output word, framing and valid
//   src_error_o                      packet was truncated, flagged on the last word
//   src_ready_i                      downstream accepts word
//   snk_descending_i                 sort direction sampled at SOP (only with PACKET_SORTER_DESC_EN)
// Optional feature macro: PACKET_SORTER_DESC_EN (default build sorts ascending)
module packet_sorter #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16,
  parameter int SIGNED_DATA = 0
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
`ifdef PACKET_SORTER_DESC_EN
  input  logic              snk_descending_i,
`endif
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  output logic              src_error_o,
  input  logic              src_ready_i
);

  localparam int LW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECEIVING, S_SORTING, S_SENDING} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     phase_q, phase_d;
  logic              trunc_q, trunc_d;
  logic              desc_q, desc_d;
  logic              desc_in;
  logic              wr_en;
  logic [LW-1:0]     wr_idx;
  logic              snk_beat, src_beat, last_word;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] mem_q  [MAX_PKT_LEN];
  logic [DWIDTH-1:0] sort_d [MAX_PKT_LEN];

`ifdef PACKET_SORTER_DESC_EN
  assign desc_in = snk_descending_i;
`else
  assign desc_in = 1'b0;
`endif

  // True when a (lower index) must move behind b for the active direction.
  // Equal words are never out of order, which keeps the sort stable.
  function automatic logic out_of_order(input logic [DWIDTH-1:0] a,
                                        input logic [DWIDTH-1:0] b,
                                        input logic              desc);
    logic gt, lt;
    if (SIGNED_DATA != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return desc ? lt : gt;
  endfunction

  // Ready is gated by reset so the sink sees 0 while arst_ni is low.
  assign snk_ready_o = arst_ni && (state_q == S_IDLE || state_q == S_RECEIVING);
  assign snk_beat    = snk_valid_i && snk_ready_o;
  assign src_valid_o = (state_q == S_SENDING);
  assign src_beat    = src_valid_o && src_ready_i;
  assign last_word   = (rd_q == len_q - 1'b1);

  // One transposition phase: pairs starting at even (phase even) or odd indices.
  // Pairs within a phase are disjoint, so reading mem_q only is safe.
  always_comb begin
    sort_d = mem_q;
    for (int i = 0; i < MAX_PKT_LEN - 1; i++) begin
      if ((i % 2) == int'(phase_q[0]) && (i + 1) < int'(len_q) &&
          out_of_order(mem_q[i], mem_q[i+1], desc_q)) begin
        sort_d[i]   = mem_q[i+1];
        sort_d[i+1] = mem_q[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MAX_PKT_LEN; i++) begin
      if (rd_q == LW'(i)) rd_word = mem_q[i];
    end
  end

  assign src_data_o          = src_valid_o ? rd_word : '0;
  assign src_startofpacket_o = src_valid_o && (rd_q == '0);
  assign src_endofpacket_o   = src_valid_o && last_word;
  assign src_error_o         = src_valid_o && last_word && trunc_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    phase_d = phase_q;
    trunc_d = trunc_q;
    desc_d  = desc_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    case (state_q)
      S_IDLE: begin
        if (snk_beat && snk_startofpacket_i) begin
          wr_en   = 1'b1;
          len_d   = LW'(1);
          trunc_d = 1'b0;
          desc_d  = desc_in;
          rd_d    = '0;
          state_d = snk_endofpacket_i ? S_SENDING : S_RECEIVING;
        end
      end
      S_RECEIVING: begin
        if (snk_beat) begin
          if (snk_startofpacket_i) begin
            wr_en   = 1'b1;
            len_d   = LW'(1);
            trunc_d = 1'b0;
            desc_d  = desc_in;
          end else if (len_q < LW'(MAX_PKT_LEN)) begin
            wr_en   = 1'b1;
            wr_idx  = len_q;
            len_d   = len_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (snk_endofpacket_i) begin
            state_d = S_SORTING;
            phase_d = '0;
          end
        end
      end
      S_SORTING: begin
        phase_d = phase_q + 1'b1;
        // len phases fully sort len words.
        if (phase_q == len_q - 1'b1) begin
          state_d = S_SENDING;
          rd_d    = '0;
          phase_d = '0;
        end
      end
      S_SENDING: begin
        if (src_beat) begin
          if (last_word) begin
            state_d = S_IDLE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      rd_q    <= '0;
      phase_q <= '0;
      trunc_q <= 1'b0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      phase_q <= phase_d;
      trunc_q <= trunc_d;
      desc_q  <= desc_d;
    end
  end

  // Packet storage carries no reset; len_q bounds every read.
  always_ff @(posedge clk_i) begin
    if (state_q == S_SORTING) begin
      mem_q <= sort_d;
    end else if (wr_en) begin
      for (int i = 0; i < MAX_PKT_LEN; i++) begin
        if (wr_idx == LW'(i)) mem_q[i] <= snk_data_i;
      end
    end
  end

endmodule
